// File: rtl/core_run_sequencer.sv
// Sequences a coprocessor core through repeated reset-hold / run / register-dump
// passes, counting run cycles and reporting whether each run ended by halt or by count.
module core_run_sequencer #(
    parameter int unsigned N            = 64,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned DUMP_CYCLES  = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [7:0]       num_runs,
    input  logic             halt,
    output logic             core_reset,
    output logic             dump,
    output logic [2:0]       coprocessorIOControl,
    output logic [N-1:0]     coprocessorIODataIn,
    output logic             busy,
    output logic             done,
    output logic [7:0]       run_index,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // One phase counter serves both the reset-hold and dump windows.
    localparam int unsigned PH_MAX = (RESET_CYCLES > DUMP_CYCLES) ? RESET_CYCLES : DUMP_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] RST_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0] DUMP_LAST = PH_W'(DUMP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    logic [7:0]       nr_q, nr_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             core_reset_q, dump_q, busy_q, done_q;

    // Next-state and run-bookkeeping decode.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        rc_d    = rc_q;
        nr_d    = nr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (start && (run_cycles != '0) && (num_runs != '0)) begin
                    state_d = S_RST;
                    ph_d    = '0;
                    rc_d    = run_cycles;
                    nr_d    = num_runs;
                    idx_d   = '0;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            S_RST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ph_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(1);
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_RUN: begin
                // Halt outranks a coincident final count.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (halt) begin
                    state_d = S_DUMP;
                    ph_d    = '0;
                    to_d    = 1'b0;
                end else if (cnt_q == rc_q) begin
                    state_d = S_DUMP;
                    ph_d    = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DUMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ph_q == DUMP_LAST) begin
                    if ((9'(idx_q) + 9'd1) < 9'(nr_q)) begin
                        state_d = S_RST;
                        ph_d    = '0;
                        idx_d   = idx_q + 8'd1;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            rc_q         <= '0;
            nr_q         <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            to_q         <= 1'b0;
            core_reset_q <= 1'b1;
            dump_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            rc_q         <= rc_d;
            nr_q         <= nr_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            core_reset_q <= (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_DONE);
            dump_q       <= (state_d == S_DUMP);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign core_reset           = core_reset_q;
    assign dump                 = dump_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign run_index            = idx_q;
    assign cycle_count          = cnt_q;
    assign timeout              = to_q;
    assign coprocessorIOControl = '0;
    assign coprocessorIODataIn  = '0;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Bench for core_run_sequencer: each sequence is expanded into a per-cycle list of
// stimulus and expected outputs, then replayed and compared every cycle.
module tb_core_run_sequencer;

    localparam int unsigned N            = 64;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned DUMP_CYCLES  = 1;

    logic             clk;
    logic             rst, start, abort, halt;
    logic [CNT_W-1:0] run_cycles;
    logic [7:0]       num_runs;
    logic             core_reset, dump, busy, done, timeout;
    logic [2:0]       ctl;
    logic [N-1:0]     din;
    logic [7:0]       run_index;
    logic [CNT_W-1:0] cycle_count;

    core_run_sequencer #(
        .N(N), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES), .DUMP_CYCLES(DUMP_CYCLES)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .start(start), .abort(abort),
        .run_cycles(run_cycles), .num_runs(num_runs), .halt(halt),
        .core_reset(core_reset), .dump(dump), .coprocessorIOControl(ctl),
        .coprocessorIODataIn(din), .busy(busy), .done(done),
        .run_index(run_index), .cycle_count(cycle_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, st, ab, hl;
        logic [CNT_W-1:0] rc;
        logic [7:0] nr;
        logic cr, dm, bs, dn;
        logic [7:0] idx;
        logic [CNT_W-1:0] cnt;
        logic to;
    } vec_t;

    vec_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model bookkeeping: persistent outputs plus the kill (abort/reset) injection point.
    int m_idx, m_cnt;
    bit m_to;
    bit dead, kill_rst, noise;
    int e, kill_edge;

    int s_run, s_dump, s_done, s_busy, s_hold, s_win;
    bit prev_run;

    function automatic void push(input bit rs, input bit st, input bit ab, input bit hl,
                                 input int rc, input int nr,
                                 input bit cr, input bit dm, input bit bs, input bit dn);
        vec_t v;
        v.rst = rs; v.st = st; v.ab = ab; v.hl = hl;
        v.rc = CNT_W'(rc); v.nr = 8'(nr);
        v.cr = cr; v.dm = dm; v.bs = bs; v.dn = dn;
        v.idx = 8'(m_idx); v.cnt = CNT_W'(m_cnt); v.to = m_to;
        q.push_back(v);
    endfunction

    function automatic void idle(input int n, input bit st, input int rc, input int nr);
        for (int i = 0; i < n; i++) push(0, st, 0, 0, rc, nr, 1, 0, 0, 0);
    endfunction

    // One clock edge of a busy sequence; may be replaced by the abort/reset edge.
    function automatic void emit(input bit killable, input bit hl,
                                 input bit cr, input bit dm, input bit bs, input bit dn,
                                 input int n_idx, input int n_cnt, input bit n_to);
        if (dead) return;
        e++;
        if (killable && e == kill_edge) begin
            dead = 1;
            if (kill_rst) begin
                m_idx = 0; m_cnt = 0; m_to = 0;
                push(1, 1, 1, 1, 3, 3, 1, 0, 0, 0);
            end else begin
                push(0, 1, 1, 1, 3, 3, 1, 0, 0, 0);
            end
            return;
        end
        m_idx = n_idx; m_cnt = n_cnt; m_to = n_to;
        push(0, noise, 0, hl, noise ? 1 : 0, noise ? 1 : 0, cr, dm, bs, dn);
    endfunction

    // Expand a whole start..done sequence: hr/hc = run and RUN-cycle of a halt,
    // ke = edge number replaced by abort (kr=0) or reset (kr=1), nz = inject ignored inputs.
    function automatic void gen(input int rc, input int nr, input int hr, input int hc,
                                input int ke, input bit kr, input bit nz);
        int  c;
        bit  fin;
        dead = 0; e = 1; kill_edge = ke; kill_rst = kr; noise = nz;
        m_idx = 0; m_cnt = 0; m_to = 0;
        push(0, 1, 0, 0, rc, nr, 1, 0, 1, 0);
        for (int r = 0; r < nr; r++) begin
            for (int i = 1; i < RESET_CYCLES; i++) emit(1, nz, 1, 0, 1, 0, m_idx, m_cnt, m_to);
            emit(1, nz, 0, 0, 1, 0, m_idx, 1, m_to);
            c = 1; fin = 0;
            while (!fin) begin
                if (r == hr && c == hc) begin
                    emit(1, 1, 0, 1, 1, 0, m_idx, c, 0);
                    fin = 1;
                end else if (c == rc) begin
                    emit(1, 0, 0, 1, 1, 0, m_idx, c, 1);
                    fin = 1;
                end else begin
                    c++;
                    emit(1, 0, 0, 0, 1, 0, m_idx, c, m_to);
                end
            end
            for (int i = 1; i < DUMP_CYCLES; i++) emit(1, nz, 0, 1, 1, 0, m_idx, m_cnt, m_to);
            if (r + 1 < nr) begin
                emit(1, nz, 1, 0, 1, 0, r + 1, 0, m_to);
            end else begin
                emit(1, nz, 1, 0, 1, 1, m_idx, m_cnt, m_to);
                emit(0, nz, 1, 0, 0, 0, m_idx, m_cnt, m_to);
            end
        end
        idle(2, 0, 0, 0);
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    task automatic run_q();
        vec_t v;
        bit   run_now;
        s_run = 0; s_dump = 0; s_done = 0; s_busy = 0; s_hold = 0; s_win = 0; prev_run = 0;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge clk);
            rst = v.rst; start = v.st; abort = v.ab; halt = v.hl;
            run_cycles = v.rc; num_runs = v.nr;
            @(posedge clk);
            #1;
            cyc++;
            chk("core_reset",  64'(core_reset),  64'(v.cr));
            chk("dump",        64'(dump),        64'(v.dm));
            chk("busy",        64'(busy),        64'(v.bs));
            chk("done",        64'(done),        64'(v.dn));
            chk("run_index",   64'(run_index),   64'(v.idx));
            chk("cycle_count", 64'(cycle_count), 64'(v.cnt));
            chk("timeout",     64'(timeout),     64'(v.to));
            chk("io_control",  64'(ctl),         64'd0);
            chk("io_data",     din,              64'd0);
            run_now = !core_reset && !dump;
            if (run_now) s_run++;
            if (run_now && !prev_run) s_win++;
            prev_run = run_now;
            if (dump) s_dump++;
            if (done) s_done++;
            if (busy) s_busy++;
            if (core_reset && busy && !done) s_hold++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst = 1; start = 0; abort = 0; halt = 0; run_cycles = '0; num_runs = '0;
        m_idx = 0; m_cnt = 0; m_to = 0;

        // Reset wins over start/abort/halt.
        for (int i = 0; i < 3; i++) push(1, 1, 1, 1, 5, 1, 1, 0, 0, 0);
        run_q();
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        // Starts with a zero length or zero run count are ignored.
        idle(3, 1, 0, 2);
        idle(3, 1, 5, 0);
        run_q();
        chk("ignored_busy_cycles", 64'(s_busy), 64'd0);
        chk("ignored_core_reset", 64'(core_reset), 64'd1);

        gen(5, 1, -1, 0, 0, 0, 0);
        run_q();
        chk("single_run_cycles", 64'(s_run), 64'd5);
        chk("single_hold_cycles", 64'(s_hold), 64'd2);
        chk("single_dump_cycles", 64'(s_dump), 64'd1);
        chk("single_done_pulses", 64'(s_done), 64'd1);
        chk("single_count", 64'(cycle_count), 64'd5);
        chk("single_timeout", 64'(timeout), 64'd1);

        gen(100, 1, 0, 3, 0, 0, 0);
        run_q();
        chk("halt_run_cycles", 64'(s_run), 64'd3);
        chk("halt_count", 64'(cycle_count), 64'd3);
        chk("halt_timeout", 64'(timeout), 64'd0);

        gen(4, 3, -1, 0, 0, 0, 1);
        run_q();
        chk("multi_windows", 64'(s_win), 64'd3);
        chk("multi_run_cycles", 64'(s_run), 64'd12);
        chk("multi_dumps", 64'(s_dump), 64'd3);
        chk("multi_done_pulses", 64'(s_done), 64'd1);
        chk("multi_run_index", 64'(run_index), 64'd2);

        gen(4, 1, 0, 4, 0, 0, 0);
        run_q();
        chk("halt_at_final_timeout", 64'(timeout), 64'd0);
        chk("halt_at_final_count", 64'(cycle_count), 64'd4);

        gen(10, 2, -1, 0, 5, 1, 0);
        run_q();
        chk("midrun_reset_done", 64'(s_done), 64'd0);
        chk("midrun_reset_count", 64'(cycle_count), 64'd0);

        gen(3, 2, -1, 0, 7, 0, 0);
        run_q();
        chk("dump_abort_done", 64'(s_done), 64'd0);
        chk("dump_abort_dumps", 64'(s_dump), 64'd1);
        chk("dump_abort_count", 64'(cycle_count), 64'd3);

        gen(1, 2, -1, 0, 0, 0, 1);
        run_q();
        chk("len1_run_cycles", 64'(s_run), 64'd2);
        chk("len1_run_index", 64'(run_index), 64'd1);

        gen(6, 2, 1, 2, 0, 0, 1);
        gen(5, 1, -1, 0, 2, 0, 0);
        run_q();
        chk("mixed_done_pulses", 64'(s_done), 64'd1);
        chk("rst_abort_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_run_sequencer.md
CORE_RUN_SEQUENCER -- requirements
Module: core_run_sequencer

Interface
REQ-001 Clocking: one clock, CLOCK_50; reset is synchronous and active-high, named reset.
REQ-002 Parameter N, default 64: coprocessor data width.
REQ-003 Parameter CNT_W, default 32: run-length counter width.
REQ-004 Parameter RESET_CYCLES, default 2 (>=1): core reset hold length per run.
REQ-005 Parameter DUMP_CYCLES, default 1 (>=1): dump pulse length per run.
REQ-006 CLOCK_50  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  begin a sequence; sampled only in IDLE.
REQ-009 abort  in  1  cancel the sequence from any busy state.
REQ-010 run_cycles  in  CNT_W  cycles per run with core out of reset; latched at start.
REQ-011 num_runs  in  8  number of back-to-back runs; latched at start.
REQ-012 halt  in  1  core-side early-stop request.
REQ-013 core_reset  out  1  reset to the core.
REQ-014 dump  out  1  register-dump request to the core.
REQ-015 coprocessorIOControl  out  3  held 0.
REQ-016 coprocessorIODataIn  out  N  held 0.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 run_index  out  8  zero-based index of the current or last run.
REQ-020 cycle_count  out  CNT_W  RUN cycles spent in the current or last run.
REQ-021 timeout  out  1  last run ended by count, not by halt.

Function
REQ-022 All outputs are registered; each takes its new value on the same edge as the state change.
REQ-023 States are IDLE, RST_HOLD, RUN, DUMP and DONE.
REQ-024 IDLE: core_reset=1, dump=0.
REQ-025 IDLE -> RST_HOLD on start=1 with run_cycles!=0 and num_runs!=0; this edge latches both inputs, clears run_index, cycle_count and timeout.
REQ-026 In IDLE, start with run_cycles=0 or num_runs=0 is ignored.
REQ-027 In every non-IDLE state, start is ignored.
REQ-028 RST_HOLD: core_reset=1, dump=0; the block stays exactly RESET_CYCLES cycles, then enters RUN.
REQ-029 RUN: core_reset=0, dump=0.
REQ-030 In RUN, cycle_count increments once per RUN cycle, so the first RUN cycle shows 1.
REQ-031 In RUN, halt=1 causes the next state to be DUMP with timeout=0.
REQ-032 In RUN, reaching cycle_count==latched run_cycles without halt causes the next state to be DUMP with timeout=1.
REQ-033 If halt and the final count occur in the same cycle, halt wins and timeout=0.
REQ-034 DUMP: core_reset=0, dump=1 for exactly DUMP_CYCLES cycles; cycle_count is held.
REQ-035 After DUMP, if run_index+1 < num_runs, the block increments run_index, clears cycle_count and returns to RST_HOLD.
REQ-036 After DUMP, if run_index+1 >= num_runs, the block enters DONE.
REQ-037 DONE lasts one cycle with done=1 and core_reset=1, then the block returns to IDLE.
REQ-038 run_index, cycle_count and timeout hold their values in IDLE until the next accepted start.
REQ-039 abort=1 in RST_HOLD, RUN or DUMP sends the block to IDLE on the next edge with core_reset=1, dump=0 and no done pulse.
REQ-040 abort has priority over halt and over count completion.
REQ-041 The cycle counter never wraps, because it is bounded by run_cycles <= 2^CNT_W-1.

Reset
REQ-042 reset=1 forces, on the next edge, from any state: state=IDLE, core_reset=1, dump=0, busy=0, done=0, run_index=0, cycle_count=0, timeout=0, latched inputs=0.
REQ-043 reset has priority over start, abort and halt.

Verification
REQ-044 start, run_cycles=5, num_runs=1, halt=0 -> core_reset=1 for 2 cycles, then 0 for 5 cycles; dump=1 for 1 cycle; done pulse; cycle_count=5; timeout=1.
REQ-045 run_cycles=100, halt=1 in the 3rd RUN cycle -> dump on the next cycle; cycle_count=3; timeout=0.
REQ-046 run_cycles=4, num_runs=3 -> three core_reset-low windows of 4 cycles, each followed by a dump; run_index steps 0,1,2; exactly one done.
REQ-047 start with run_cycles=0 -> busy stays 0 and core_reset stays 1; halt coincident with cycle_count==run_cycles -> timeout=0.
REQ-048 reset mid-RUN -> IDLE next edge with all REQ-042 values; abort during DUMP -> IDLE with no done pulse.
